rs_preio_bus: RTL

RS_PREIO_BUS -- requirements
Module: rs_preio_bus

---
 rtl/rs_preio_bus.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rs_preio_bus.sv
// Bidirectional FPGA<->SoC pre-IO bus: two independent FWFT FIFOs plus a loopback mode, 1-cycle push-to-read latency.
// Backpressure: write READY drops when a FIFO is full; loopback pauses F2S pops while S2F is full.

module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_rdy,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign push_rdy = (level != LW'(DEPTH));
   assign pop_vld  = (level != LW'(0));
   assign pop_dat  = mem[rd_ptr];
   assign push     = push_vld & push_rdy;
   assign pop      = pop_vld & pop_rdy;

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wr_ptr] <= push_dat;
   end

endmodule

module rs_preio_bus #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             FPGA_CLK,
   input  logic             FPGA_RST_N,
   output logic             SOC_CLK,
   input  logic [WIDTH-1:0] FPGA_OUT,
   input  logic             FPGA_OUT_VALID,
   output logic             FPGA_OUT_READY,
   output logic [WIDTH-1:0] SOC_OUT,
   output logic             SOC_OUT_VALID,
   input  logic             SOC_OUT_READY,
   input  logic [WIDTH-1:0] SOC_IN,
   input  logic             SOC_IN_VALID,
   output logic             SOC_IN_READY,
   output logic [WIDTH-1:0] FPGA_IN,
   output logic             FPGA_IN_VALID,
   input  logic             FPGA_IN_READY,
   input  logic             LOOPBACK,
   output logic             LB_ACTIVE,
   output logic [LW-1:0]    F2S_LEVEL,
   output logic [LW-1:0]    S2F_LEVEL
);

   logic             f2s_pop_vld;
   logic             f2s_pop_rdy;
   logic [WIDTH-1:0] f2s_pop_dat;
   logic             s2f_push_vld;
   logic             s2f_push_rdy;
   logic [WIDTH-1:0] s2f_push_dat;

   assign SOC_CLK = FPGA_CLK;

   // Mode only changes with both FIFOs empty so no word is split across modes
   always_ff @(posedge FPGA_CLK) begin
      if (!FPGA_RST_N)
         LB_ACTIVE <= 1'b0;
      else if (F2S_LEVEL == LW'(0) && S2F_LEVEL == LW'(0))
         LB_ACTIVE <= LOOPBACK;
   end

   assign f2s_pop_rdy   = LB_ACTIVE ? s2f_push_rdy : SOC_OUT_READY;
   assign SOC_OUT_VALID = f2s_pop_vld & ~LB_ACTIVE;
   assign SOC_OUT       = f2s_pop_dat;

   assign s2f_push_vld  = LB_ACTIVE ? f2s_pop_vld : SOC_IN_VALID;
   assign s2f_push_dat  = LB_ACTIVE ? f2s_pop_dat : SOC_IN;
   assign SOC_IN_READY  = s2f_push_rdy & ~LB_ACTIVE;

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f2s_fifo (
      .clk      (FPGA_CLK),
      .rst_n    (FPGA_RST_N),
      .push_vld (FPGA_OUT_VALID),
      .push_dat (FPGA_OUT),
      .push_rdy (FPGA_OUT_READY),
      .pop_vld  (f2s_pop_vld),
      .pop_rdy  (f2s_pop_rdy),
      .pop_dat  (f2s_pop_dat),
      .level    (F2S_LEVEL)
   );

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_s2f_fifo (
      .clk      (FPGA_CLK),
      .rst_n    (FPGA_RST_N),
      .push_vld (s2f_push_vld),
      .push_dat (s2f_push_dat),
      .push_rdy (s2f_push_rdy),
      .pop_vld  (FPGA_IN_VALID),
      .pop_rdy  (FPGA_IN_READY),
      .pop_dat  (FPGA_IN),
      .level    (S2F_LEVEL)
   );

endmodule
